// File: rtl/dice_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dice_pkg : states, die range and die width shared by the dice round control.
// Rev 1.0
// ---------------------------------------------------------------------------
package dice_pkg;

  localparam int DIE_W = 4;
  localparam logic [DIE_W-1:0] DIE_MIN = 4'd1;
  localparam logic [DIE_W-1:0] DIE_MAX = 4'd6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P1_ROLL = 3'd1,
    P1_DONE = 3'd2,
    P2_ROLL = 3'd3,
    P2_DONE = 3'd4,
    FIN     = 3'd5,
    SETTLE  = 3'd6,
    SHOW    = 3'd7
  } state_t;

  function automatic logic die_ok(input logic [DIE_W-1:0] d);
    return (d >= DIE_MIN) && (d <= DIE_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_debounce : 2-flop synchroniser, stable-count debouncer, rise/fall pulses.
// Rev 1.0
// ---------------------------------------------------------------------------
module key_debounce #(
  parameter int DB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic rise,
  output logic fall
);

  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic          done;

  assign done = (cnt == CW'(DB_CYCLES - 1));

  // Counter tracks consecutive samples that disagree with the debounced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], key};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (done) begin
        level <= sync[1];
        cnt   <= '0;
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dice_round_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dice_round_ctrl : round sequencer and judge for the dice roller.
// Optional cumulative scores enabled by DICE_SCORE_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module dice_round_ctrl
  import dice_pkg::*;
#(
  parameter int DB_CYCLES     = 20,
  parameter int FIN_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int SCORE_MAX     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key1,
  input  logic             key2,
  input  logic             key_fin,
  input  logic [DIE_W-1:0] dice1,
  input  logic [DIE_W-1:0] dice2,
  output logic             start1,
  output logic             start2,
  output logic             finish,
  output logic             win1,
  output logic             win2,
  output logic             draw,
  output logic             err,
  output logic             res_valid,
  output logic [3:0]       score1,
  output logic [3:0]       score2,
  output logic [2:0]       state_dbg
);

  state_t     state;
  logic [7:0] tcnt;
  logic       r1, f1, r2, f2, rf, ff_unused;
  logic       dice_ok, d_gt, d_lt, enter_show;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db1 (
    .clk(clk), .rst(rst), .key(key1), .rise(r1), .fall(f1)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db2 (
    .clk(clk), .rst(rst), .key(key2), .rise(r2), .fall(f2)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_dbf (
    .clk(clk), .rst(rst), .key(key_fin), .rise(rf), .fall(ff_unused)
  );

  assign dice_ok    = die_ok(dice1) && die_ok(dice2);
  assign d_gt       = dice1 > dice2;
  assign d_lt       = dice1 < dice2;
  assign enter_show = (state == SETTLE) && (tcnt == 8'(SETTLE_CYCLES - 1));
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tcnt      <= 8'd0;
      start1    <= 1'b0;
      start2    <= 1'b0;
      finish    <= 1'b0;
      win1      <= 1'b0;
      win2      <= 1'b0;
      draw      <= 1'b0;
      err       <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (r1) begin
          state  <= P1_ROLL;
          start1 <= 1'b1;
        end
        P1_ROLL: if (f1) begin
          state  <= P1_DONE;
          start1 <= 1'b0;
        end
        P1_DONE: if (r2) begin
          state  <= P2_ROLL;
          start2 <= 1'b1;
        end
        P2_ROLL: if (f2) begin
          state  <= P2_DONE;
          start2 <= 1'b0;
        end
        P2_DONE: if (rf) begin
          state  <= FIN;
          finish <= 1'b1;
          tcnt   <= 8'd0;
        end
        FIN: begin
          if (tcnt == 8'(FIN_CYCLES - 1)) begin
            state  <= SETTLE;
            finish <= 1'b0;
            tcnt   <= 8'd0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        SETTLE: begin
          // Dice are sampled only after the roller has had time to settle.
          if (enter_show) begin
            state     <= SHOW;
            res_valid <= 1'b1;
            err       <= ~dice_ok;
            win1      <= dice_ok & d_gt;
            win2      <= dice_ok & d_lt;
            draw      <= dice_ok & ~d_gt & ~d_lt;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        SHOW: if (rf) begin
          state     <= IDLE;
          res_valid <= 1'b0;
          win1      <= 1'b0;
          win2      <= 1'b0;
          draw      <= 1'b0;
          err       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DICE_SCORE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score1 <= 4'd0;
      score2 <= 4'd0;
    end else if (enter_show && dice_ok) begin
      if (d_gt && (score1 < 4'(SCORE_MAX))) score1 <= score1 + 4'd1;
      if (d_lt && (score2 < 4'(SCORE_MAX))) score2 <= score2 + 4'd1;
    end
  end
`else
  assign score1 = 4'd0;
  assign score2 = 4'd0;
`endif

endmodule
`default_nettype wire
